// File: rtl/ahb3lite_sram_slave.sv
// rtl/ahb3lite_sram_slave.sv - AHB3-lite responder in front of a single-port word RAM
//
// Purpose: AHB3-lite slave fronting an on-chip word RAM. Adds a programmable
// number of data-phase wait states to every OKAY transfer. Writes go to the
// addressed byte lanes, and reads always return the full word. Illegal
// transfers get a two-cycle ERROR response and never touch the RAM.
//
// Optional feature macro: AHB_SRAM_EXCL_EN adds the exclusive-access ports
// EXREQ/EXRESP and a single-entry exclusive monitor.
//
// Parameters:
//   ADDR_WIDTH  - byte-address bits decoded; RAM holds 2**(ADDR_WIDTH-2) words
//   WAIT_STATES - data-phase wait cycles per OKAY transfer (0..7)
//
// Ports:
//   HCLK       in   system clock
//   HRESETn    in   asynchronous active-low reset
//   HSEL       in   slave select
//   HADDR      in   [31:0] address-phase address (bits above ADDR_WIDTH ignored)
//   HTRANS     in   [1:0] IDLE/BUSY/NONSEQ/SEQ
//   HSIZE      in   [2:0] 0=byte 1=half 2=word
//   HWRITE     in   1=write
//   HWDATA     in   [31:0] write data, data phase
//   HREADY     in   bus-level ready
//   EXREQ      in   exclusive request, address phase (AHB_SRAM_EXCL_EN only)
//   EXRESP     out  1=exclusive failed, final data cycle (AHB_SRAM_EXCL_EN only)
//   HRDATA     out  [31:0] read data, final data-phase cycle, else 0
//   HREADYOUT  out  this slave's ready
//   HRESP      out  0=OKAY 1=ERROR

module ahb3lite_sram_slave #(
  parameter int ADDR_WIDTH  = 14,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
`ifdef AHB_SRAM_EXCL_EN
  input  logic        EXREQ,
  output logic        EXRESP,
`endif
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int IW    = ADDR_WIDTH - 2;
  localparam int WORDS = 2 ** IW;
  localparam logic [2:0] WS_M1 = 3'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t                  state;
  logic [2:0]              cnt;
  logic                    dp_valid;   // legal transfer currently in its data phase
  logic [ADDR_WIDTH-1:0]   dp_addr;
  logic [1:0]              dp_size;
  logic                    dp_write;

  logic [31:0]             mem [WORDS];
  logic [31:0]             rdata_q;
  logic [31:0]             fwd_word;

  logic                    accept;
  logic                    illegal;
  logic                    final_cycle;
  logic                    excl_ok;
  logic                    we_commit;
  logic [3:0]              lanes;
  logic [IW-1:0]           wr_idx;
  logic [IW-1:0]           ld_idx;

  logic                    unused_ok;
  assign unused_ok = ^{HADDR[31:ADDR_WIDTH], HTRANS[0]};

  // Transfers are only taken while idle; an accept seen during ERR2 is dropped.
  assign accept  = HSEL & HTRANS[1] & HREADY & (state == ST_IDLE);
  assign illegal = (HSIZE > 3'd2)
                 | ((HSIZE == 3'd1) & HADDR[0])
                 | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));

  // The final data-phase cycle is the one where an accepted legal transfer
  // sees this slave back in IDLE with HREADYOUT high.
  assign final_cycle = (state == ST_IDLE) & dp_valid;
  assign wr_idx      = dp_addr[ADDR_WIDTH-1:2];

  always_comb begin
    lanes = 4'b0000;
    case (dp_size)
      2'd0:    lanes = 4'b0001 << dp_addr[1:0];
      2'd1:    lanes = dp_addr[1] ? 4'b1100 : 4'b0011;
      default: lanes = 4'b1111;
    endcase
  end

`ifdef AHB_SRAM_EXCL_EN
  logic          dp_excl;
  logic          mon_valid;
  logic [IW-1:0] mon_idx;

  // Exclusive writes only land when the monitor still holds their word.
  assign excl_ok = ~dp_excl | (mon_valid & (mon_idx == wr_idx));
  assign EXRESP  = final_cycle & dp_write & dp_excl & ~excl_ok;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_excl   <= 1'b0;
      mon_valid <= 1'b0;
      mon_idx   <= '0;
    end else begin
      if (accept) begin
        dp_excl <= EXREQ;
      end
      if (final_cycle) begin
        if (dp_excl && !dp_write) begin
          mon_valid <= 1'b1;
          mon_idx   <= wr_idx;
        end else if (dp_write && excl_ok && mon_valid && (mon_idx == wr_idx)) begin
          // Any committed write to the watched word breaks the reservation.
          mon_valid <= 1'b0;
        end
      end
    end
  end
`else
  assign excl_ok = 1'b1;
`endif

  assign we_commit = final_cycle & dp_write & excl_ok;

  // Read data is registered. It is loaded from the address being accepted now,
  // or from the held address while waiting. A write that commits on the same
  // edge is merged lane by lane so a back-to-back read sees it with no stall.
  assign ld_idx = accept ? HADDR[ADDR_WIDTH-1:2] : wr_idx;

  always_comb begin
    fwd_word = mem[ld_idx];
    for (int b = 0; b < 4; b++) begin
      if (we_commit && lanes[b] && (ld_idx == wr_idx)) begin
        fwd_word[8*b +: 8] = HWDATA[8*b +: 8];
      end
    end
  end

  always_ff @(posedge HCLK) begin
    for (int b = 0; b < 4; b++) begin
      if (we_commit && lanes[b]) begin
        mem[wr_idx][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
    rdata_q <= fwd_word;
  end

  assign HRDATA = (final_cycle && !dp_write) ? rdata_q : 32'h0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      cnt       <= 3'd0;
      dp_valid  <= 1'b0;
      dp_addr   <= '0;
      dp_size   <= 2'd0;
      dp_write  <= 1'b0;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            dp_addr  <= HADDR[ADDR_WIDTH-1:0];
            dp_size  <= HSIZE[1:0];
            dp_write <= HWRITE;
            if (illegal) begin
              dp_valid  <= 1'b0;
              state     <= ST_ERR1;
              HREADYOUT <= 1'b0;
              HRESP     <= 1'b1;
            end else begin
              dp_valid <= 1'b1;
              HRESP    <= 1'b0;
              if (WAIT_STATES > 0) begin
                state     <= ST_WAIT;
                cnt       <= WS_M1;
                HREADYOUT <= 1'b0;
              end else begin
                HREADYOUT <= 1'b1;
              end
            end
          end else begin
            dp_valid  <= 1'b0;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
          end
        end
        ST_WAIT: begin
          HRESP <= 1'b0;
          if (cnt == 3'd0) begin
            state     <= ST_IDLE;
            HREADYOUT <= 1'b1;
          end else begin
            cnt       <= cnt - 3'd1;
            HREADYOUT <= 1'b0;
          end
        end
        ST_ERR1: begin
          state     <= ST_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b1;
        end
        ST_ERR2: begin
          state     <= ST_IDLE;
          dp_valid  <= 1'b0;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          dp_valid  <= 1'b0;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b0;
        end
      endcase
    end
  end

endmodule
